// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite bus bundle between a master/interconnect and ahb_slave_mem
//
// Purpose: groups the address-phase, data-phase and response signals of one
// AHB-Lite slave port.
// Signals:
//   hsel, haddr, hwrite, hsize, hburst, htrans : address phase (master -> slave)
//   hwdata                                     : write data, data phase (master -> slave)
//   hready                                     : bus-level ready (interconnect -> both)
//   hrdata, hreadyout, hresp                   : slave response (slave -> master)
interface ahb_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [1:0]            htrans;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, htrans, hwdata, hready,
        output hrdata, hreadyout, hresp
    );

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, htrans, hwdata,
        input  hready, hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite memory slave with programmable wait states and ERROR response
//
// Purpose: MEM_DEPTH words of 32-bit byte-addressable storage behind an AHB-Lite
// slave port. OKAY transfers insert WAIT_STATES hreadyout-low cycles; bad size,
// misaligned or out-of-range transfers get the two-cycle ERROR response.
// Ports:
//   hclk   : clock, all state on the rising edge
//   hreset : asynchronous active-high reset, clears FSM, registers and memory
//   bus    : ahb_slave_mem_if slave modport (address/data phase in, response out)
// Addressing assumes 4-byte words (DATA_WIDTH = 32).
module ahb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_slave_mem_if.slave  bus
);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam logic [2:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [2:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_error;
    logic                  w_hreadyout;
    logic                  w_hresp;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_LANES-1:0]  w_be;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_unused;

    // Address phases are only sampled while this slave is not stalling the
    // bus; during wait/ERR1 cycles the master is holding an extended phase.
    assign w_accept = bus.hsel && bus.hready && bus.htrans[1] && w_hreadyout;

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.hsize)
            3'b001:  w_misaligned = bus.haddr[0];
            3'b010:  w_misaligned = |bus.haddr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_error = (bus.hsize > 3'b010) || w_misaligned || (bus.haddr >= MEM_BYTES);
    assign w_idx   = r_addr[IDX_W+1:2];

    // State register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; IDLE, DATA and ERR2 all complete a phase and may
    // take the next address phase back to back.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_next = S_DATA;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_error) begin
                        w_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_DATA;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        w_rdata     = '0;
        case (r_state)
            S_WAIT: w_hreadyout = 1'b0;
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
            end
            S_ERR2: w_hresp = 1'b1;
            S_DATA: begin
                if (!r_write) begin
                    w_rdata = r_mem[w_idx];
                end
            end
            default: w_hreadyout = 1'b1;
        endcase
    end

    assign bus.hreadyout = w_hreadyout;
    assign bus.hresp     = w_hresp;
    assign bus.hrdata    = w_rdata;

    // Address/control captured at acceptance and held through the data phase
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'b000;
        end else if (w_accept) begin
            r_addr  <= bus.haddr;
            r_write <= bus.hwrite;
            r_size  <= bus.hsize;
        end
    end

    // Loaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_wait_cnt <= 3'd0;
        end else if (w_accept && !w_error) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if (r_state == S_WAIT && r_wait_cnt != 3'd0) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

    // Little-endian byte lanes of the registered transfer
    always_comb begin
        w_be = '0;
        for (int b = 0; b < NUM_LANES; b++) begin
            case (r_size)
                3'b000:  w_be[b] = (r_addr[1:0] == 2'(b));
                3'b001:  w_be[b] = (r_addr[1] == 1'(b / 2));
                default: w_be[b] = 1'b1;
            endcase
        end
    end

    // Writes land at the end of DATA, so a read whose DATA cycle follows
    // sees the new word without a bypass path.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_DATA && r_write) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    // Burst type is irrelevant since each beat is decoded on its own
    assign w_unused = ^{bus.hburst, r_addr[ADDR_WIDTH-1:IDX_W+2]};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem with 0, 1 and 3 wait states
module tb_ahb_slave_mem;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int NDUT  = 3;

    typedef struct {
        bit          err;
        bit          wr;
        logic [31:0] rdata;
        int          ws;
    } exp_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    // Shared master; sel picks which slave the decoder enables
    int          sel = 0;
    logic        m_hsel = 1'b0;
    logic [31:0] m_haddr = '0;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize = 3'd0;
    logic [2:0]  m_hburst = 3'd0;
    logic [1:0]  m_htrans = 2'd0;
    logic [31:0] m_hwdata = '0;
    logic        w_hready;
    logic        w_hresp;
    logic [31:0] w_hrdata;

    ahb_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    ahb_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    ahb_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

    ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(1))
        dut0 (.hclk(hclk), .hreset(hreset), .bus(b0));
    ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
        dut1 (.hclk(hclk), .hreset(hreset), .bus(b1));
    ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3))
        dut2 (.hclk(hclk), .hreset(hreset), .bus(b2));

    assign w_hready = (sel == 0) ? b0.hreadyout : (sel == 1) ? b1.hreadyout : b2.hreadyout;
    assign w_hresp  = (sel == 0) ? b0.hresp     : (sel == 1) ? b1.hresp     : b2.hresp;
    assign w_hrdata = (sel == 0) ? b0.hrdata    : (sel == 1) ? b1.hrdata    : b2.hrdata;

    assign b0.hsel = m_hsel && (sel == 0);
    assign b1.hsel = m_hsel && (sel == 1);
    assign b2.hsel = m_hsel && (sel == 2);
    assign b0.haddr = m_haddr;    assign b1.haddr = m_haddr;    assign b2.haddr = m_haddr;
    assign b0.hwrite = m_hwrite;  assign b1.hwrite = m_hwrite;  assign b2.hwrite = m_hwrite;
    assign b0.hsize = m_hsize;    assign b1.hsize = m_hsize;    assign b2.hsize = m_hsize;
    assign b0.hburst = m_hburst;  assign b1.hburst = m_hburst;  assign b2.hburst = m_hburst;
    assign b0.htrans = m_htrans;  assign b1.htrans = m_htrans;  assign b2.htrans = m_htrans;
    assign b0.hwdata = m_hwdata;  assign b1.hwdata = m_hwdata;  assign b2.hwdata = m_hwdata;
    assign b0.hready = w_hready;  assign b1.hready = w_hready;  assign b2.hready = w_hready;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_busy = 1'b0;
    bit   mon_last;
    int   mon_k = 0;

    // Byte-level reference memory, one per slave
    logic [7:0] ref_mem [NDUT][64];

    function automatic int ws_for(input int s);
        case (s)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1 && addr[0]) return 1'b1;
        if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
        return addr >= 32'(DEPTH * 4);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NDUT; s++)
            for (int a = 0; a < 64; a++)
                ref_mem[s][a] = 8'h00;
    endfunction

    function automatic void model_write(input int s, input logic [31:0] addr,
                                        input logic [2:0] size, input logic [31:0] data);
        int n = 1 << size;
        for (int b = 0; b < n; b++) begin
            int a = int'(addr) + b;
            ref_mem[s][a] = data[8*(a%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int s, input logic [31:0] addr);
        int base = int'(addr) & ~3;
        return {ref_mem[s][base+3], ref_mem[s][base+2], ref_mem[s][base+1], ref_mem[s][base]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Monitor: walks each data phase against the queued expectation
    always @(negedge hclk) begin
        if (hreset) begin
            sb_q.delete();
            mon_busy = 1'b0;
        end else begin
            if (mon_busy) begin
                mon_e    = sb_q[0];
                mon_last = (mon_k == (mon_e.err ? 1 : mon_e.ws));
                check(mon_e.err ? "err_hreadyout" : "ok_hreadyout", {31'd0, w_hready}, {31'd0, mon_last});
                check(mon_e.err ? "err_hresp" : "ok_hresp", {31'd0, w_hresp}, {31'd0, mon_e.err});
                check(mon_e.wr ? "wr_hrdata" : "rd_hrdata", w_hrdata,
                      (mon_last && !mon_e.err && !mon_e.wr) ? mon_e.rdata : 32'd0);
                mon_k++;
                if (mon_last) begin
                    void'(sb_q.pop_front());
                    mon_busy = 1'b0;
                end
            end else begin
                check("idle_hreadyout", {31'd0, w_hready}, 32'd1);
                check("idle_hresp", {31'd0, w_hresp}, 32'd0);
                check("idle_hrdata", w_hrdata, 32'd0);
            end
            if (!mon_busy && m_hsel && m_htrans[1] && w_hready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    mon_busy = 1'b1;
                    mon_k    = 0;
                end
            end
        end
    end

    // Returns #1 after the edge at which hready was high
    task automatic wait_ready_edge();
        int n = 0;
        bit r;
        do begin
            @(negedge hclk);
            r = w_hready;
            @(posedge hclk);
            n++;
        end while (!r && n < 50);
        if (!r) check("ready_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
        exp_t e;
        m_hsel   = 1'b1;
        m_haddr  = addr;
        m_hwrite = wr;
        m_hsize  = size;
        m_htrans = 2'b10;
        m_hburst = 3'($urandom_range(0, 7));
        e.err    = is_err(addr, size);
        e.wr     = wr;
        e.ws     = ws_for(sel);
        e.rdata  = 32'd0;
        if (!e.err) begin
            if (wr) model_write(sel, addr, size, wdata);
            else    e.rdata = model_read(sel, addr);
        end
        sb_q.push_back(e);
        wait_ready_edge();
        m_hwdata = wdata;
    endtask

    // Same as xfer, but scribbles over the address bus during the wait cycles
    task automatic xfer_hold(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        xfer(wr, addr, size, wdata);
        for (int k = 0; k < ws_for(sel); k++) begin
            m_hsel   = 1'($urandom_range(0, 1));
            m_htrans = 2'($urandom_range(0, 3));
            m_haddr  = $urandom;
            m_hwrite = 1'($urandom_range(0, 1));
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic idle_bus(input bit keep_sel, input logic [1:0] tr);
        m_hsel   = keep_sel;
        m_htrans = tr;
        m_haddr  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        idle_bus(1'b0, 2'b00);
        while ((sb_q.size() != 0 || mon_busy) && n < 100) begin
            @(posedge hclk);
            n++;
        end
        if (sb_q.size() != 0 || mon_busy) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
            mon_busy = 1'b0;
        end
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        model_clear();
        repeat (2) @(posedge hclk);
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            #1;
            check("reset_hreadyout", {31'd0, w_hready}, 32'd1);
            check("reset_hresp", {31'd0, w_hresp}, 32'd0);
            check("reset_hrdata", w_hrdata, 32'd0);
        end
        sel = 0;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // One wait state: write/read, byte lane merge, error responses
        xfer(1'b1, 32'h08, 3'd2, 32'hDEADBEEF);
        xfer(1'b0, 32'h08, 3'd2, $urandom);
        drain();
        xfer(1'b1, 32'h0C, 3'd2, 32'h11223344);
        idle_bus(1'b0, 2'b00);
        @(posedge hclk);
        #1;
        xfer(1'b1, 32'h0E, 3'd0, 32'h00AB0000);   // byte lane 2 of word 0x0C
        xfer(1'b0, 32'h0C, 3'd2, $urandom);
        drain();
        xfer(1'b1, 32'h40, 3'd2, 32'hFFFFFFFF);
        xfer(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF);
        xfer(1'b1, 32'h08, 3'd3, 32'hFFFFFFFF);
        xfer(1'b1, 32'h01, 3'd1, 32'hFFFFFFFF);
        xfer(1'b0, 32'h08, 3'd2, $urandom);
        xfer(1'b0, 32'h00, 3'd2, $urandom);
        drain();
        idle_bus(1'b1, 2'b01);
        repeat (3) @(posedge hclk);
        #1;
        idle_bus(1'b1, 2'b00);
        repeat (2) @(posedge hclk);
        #1;
        drain();

        // Zero wait states: back-to-back write then read
        sel = 1;
        xfer(1'b1, 32'h04, 3'd2, 32'h00000055);
        xfer(1'b0, 32'h04, 3'd2, $urandom);
        drain();

        // Three wait states with the address bus changing underneath
        sel = 2;
        xfer_hold(1'b1, 32'h10, 3'd2, 32'h12345678);
        idle_bus(1'b0, 2'b00);
        @(posedge hclk);
        #1;
        xfer_hold(1'b0, 32'h10, 3'd2, $urandom);
        drain();

        // Randomized traffic on every slave, then read back every word
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            for (int i = 0; i < 40; i++) begin
                sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                a  = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~(32'((1 << sz) - 1));
                if ($urandom_range(0, 9) == 0) a = 32'd64 + 32'($urandom_range(0, 63));
                xfer(1'($urandom_range(0, 1)), a, sz, $urandom);
                if ($urandom_range(0, 2) == 0) begin
                    idle_bus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)));
                    repeat ($urandom_range(1, 3)) @(posedge hclk);
                    #1;
                end
            end
            for (int w = 0; w < DEPTH; w++) xfer(1'b0, 32'(w * 4), 3'd2, $urandom);
            drain();
        end

        // Reset during the wait cycle of a write
        sel = 0;
        xfer(1'b1, 32'h00, 3'd2, 32'hCAFEF00D);
        hreset = 1'b1;
        #1;
        check("midrst_hreadyout", {31'd0, w_hready}, 32'd1);
        check("midrst_hresp", {31'd0, w_hresp}, 32'd0);
        check("midrst_hrdata", w_hrdata, 32'd0);
        idle_bus(1'b0, 2'b00);
        repeat (2) @(posedge hclk);
        model_clear();
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;
        xfer(1'b0, 32'h00, 3'd2, $urandom);
        xfer(1'b0, 32'h08, 3'd2, $urandom);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
